// File: rtl/store_buffer_if.sv
// store_buffer_if -- bundles the MEM-stage store/load handshake and the
// data-memory write port of the store buffer.
//   slave  : the store buffer (accepts stores and loads, drives dm_*).
//   master : the pipeline/memory side (drives stores, loads, dm_ready).
// Signals:
//   st_valid/st_ready, st_addr/st_wdata/st_pc[31:0], st_be[3:0]  store request
//   ld_valid, ld_addr[31:0], ld_be[3:0]                          load probe
//   ld_stall, fwd_valid, fwd_data[31:0]                          load response
//   dm_we/dm_ready, dm_addr/dm_wdata/dm_pc[31:0], dm_be[3:0]     memory write
interface store_buffer_if;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_wdata;
  logic [31:0] st_pc;
  logic [3:0]  st_be;

  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [3:0]  ld_be;
  logic        ld_stall;
  logic        fwd_valid;
  logic [31:0] fwd_data;

  logic        dm_we;
  logic        dm_ready;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_pc;
  logic [3:0]  dm_be;

  modport slave (
    input  st_valid, st_addr, st_wdata, st_pc, st_be,
    output st_ready,
    input  ld_valid, ld_addr, ld_be,
    output ld_stall, fwd_valid, fwd_data,
    output dm_we, dm_addr, dm_wdata, dm_pc, dm_be,
    input  dm_ready
  );

  modport master (
    output st_valid, st_addr, st_wdata, st_pc, st_be,
    input  st_ready,
    output ld_valid, ld_addr, ld_be,
    input  ld_stall, fwd_valid, fwd_data,
    input  dm_we, dm_addr, dm_wdata, dm_pc, dm_be,
    output dm_ready
  );
endinterface

// File: rtl/store_buffer.sv
// store_buffer -- in-order FIFO of committed stores between the MEM stage and
// data memory, with load address disambiguation.
// Ports:
//   clk  : clock, all state updates on the rising edge
//   rst  : synchronous, active-high reset; discards all queued stores
//   sb   : store_buffer_if.slave (store request, load probe, memory write port)
// Parameter:
//   DEPTH : number of queued stores (2, 4 or 8)
// Build option:
//   STORE_BUFFER_FWD_EN : when defined, a load whose lanes are fully covered by
//   the youngest matching entry is forwarded from the buffer instead of stalled.
module store_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input logic          clk,
  input logic          rst,
  store_buffer_if.slave sb
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  // Entry storage: word address, data, byte enables, PC.
  logic [29:0] addr_q [DEPTH];
  logic [29:0] addr_d [DEPTH];
  logic [31:0] data_q [DEPTH];
  logic [31:0] data_d [DEPTH];
  logic [3:0]  be_q   [DEPTH];
  logic [3:0]  be_d   [DEPTH];
  logic [31:0] pc_q   [DEPTH];
  logic [31:0] pc_d   [DEPTH];

  logic [DEPTH-1:0] valid_q, valid_d;
  ptr_t             head_q, head_d;
  ptr_t             tail_q, tail_d;
  cnt_t             count_q, count_d;

  logic enq;
  logic deq;
  logic st_ready;
  logic dm_we;

  // Full/empty are decided from the registered count only, so st_ready never
  // depends on dm_ready.
  assign st_ready = (count_q < cnt_t'(DEPTH));
  assign dm_we    = (count_q != '0);
  assign enq      = sb.st_valid && st_ready;
  assign deq      = dm_we && sb.dm_ready;

  always_comb begin : queue_next
    addr_d  = addr_q;
    data_d  = data_q;
    be_d    = be_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    if (deq) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + ptr_t'(1);
    end

    // Enqueue follows dequeue so that, when full is not possible here
    // (enq implies not full), the tail slot is never the one being freed.
    if (enq) begin
      addr_d[tail_q]  = sb.st_addr[31:2];
      data_d[tail_q]  = sb.st_wdata;
      be_d[tail_q]    = sb.st_be;
      pc_d[tail_q]    = sb.st_pc;
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + ptr_t'(1);
    end

    case ({enq, deq})
      2'b10:   count_d = count_q + cnt_t'(1);
      2'b01:   count_d = count_q - cnt_t'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload needs no reset: it is only observed through valid/count.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
    be_q   <= be_d;
    pc_q   <= pc_d;
  end

  // Head entry to data memory; zeros when empty.
  always_comb begin : dm_out
    sb.st_ready = st_ready;
    sb.dm_we    = dm_we;
    sb.dm_addr  = '0;
    sb.dm_wdata = '0;
    sb.dm_pc    = '0;
    sb.dm_be    = '0;
    if (dm_we) begin
      sb.dm_addr  = {addr_q[head_q], 2'b00};
      sb.dm_wdata = data_q[head_q];
      sb.dm_pc    = pc_q[head_q];
      sb.dm_be    = be_q[head_q];
    end
  end

  // Load lookup: walk oldest to youngest so the last hit is the youngest
  // matching entry. Only registered entries take part, never the store being
  // presented this cycle.
  logic        hit;
  logic [3:0]  hit_be;
  logic [31:0] hit_data;

  always_comb begin : load_lookup
    ptr_t idx;
    idx      = '0;
    hit      = 1'b0;
    hit_be   = '0;
    hit_data = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = head_q + ptr_t'(k);
      if (valid_q[idx] && (addr_q[idx] == sb.ld_addr[31:2])) begin
        hit      = 1'b1;
        hit_be   = be_q[idx];
        hit_data = data_q[idx];
      end
    end
  end

`ifdef STORE_BUFFER_FWD_EN
  logic fwd_ok;
  assign fwd_ok = hit && ((hit_be & sb.ld_be) == sb.ld_be);

  always_comb begin : load_resp
    sb.ld_stall  = sb.ld_valid && hit && !fwd_ok;
    sb.fwd_valid = sb.ld_valid && fwd_ok;
    sb.fwd_data  = (sb.ld_valid && fwd_ok) ? hit_data : '0;
  end

  logic unused_bits;
  assign unused_bits = ^{sb.st_addr[1:0], sb.ld_addr[1:0]};
`else
  always_comb begin : load_resp
    sb.ld_stall  = sb.ld_valid && hit;
    sb.fwd_valid = 1'b0;
    sb.fwd_data  = '0;
  end

  // Lanes and forwarded data only matter when forwarding is built in.
  logic unused_bits;
  assign unused_bits = ^{sb.st_addr[1:0], sb.ld_addr[1:0], sb.ld_be,
                         hit_be, hit_data};
`endif

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  store_buffer_if sb_if();

  store_buffer #(.DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    sb_if.st_valid = 1'b0;
    sb_if.st_addr  = '0;
    sb_if.st_wdata = '0;
    sb_if.st_pc    = '0;
    sb_if.st_be    = '0;
    sb_if.ld_valid = 1'b0;
    sb_if.ld_addr  = '0;
    sb_if.ld_be    = '0;
    sb_if.dm_ready = 1'b0;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic put_store(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] be, input logic [31:0] pc);
    sb_if.st_valid = 1'b1;
    sb_if.st_addr  = a;
    sb_if.st_wdata = d;
    sb_if.st_be    = be;
    sb_if.st_pc    = pc;
  endtask

  task automatic test_reset;
    do_reset();
    #1;
    checks++; if (sb_if.st_ready !== 1'b1) begin failures++; $display("FAIL reset_st_ready actual=%b required=1", sb_if.st_ready); end
    checks++; if (sb_if.dm_we !== 1'b0) begin failures++; $display("FAIL reset_dm_we actual=%b required=0", sb_if.dm_we); end
    checks++; if (sb_if.dm_addr !== 32'h0) begin failures++; $display("FAIL reset_dm_addr actual=%h required=0", sb_if.dm_addr); end
    checks++; if (sb_if.dm_wdata !== 32'h0) begin failures++; $display("FAIL reset_dm_wdata actual=%h required=0", sb_if.dm_wdata); end
    checks++; if (sb_if.dm_pc !== 32'h0) begin failures++; $display("FAIL reset_dm_pc actual=%h required=0", sb_if.dm_pc); end
    checks++; if (sb_if.dm_be !== 4'h0) begin failures++; $display("FAIL reset_dm_be actual=%h required=0", sb_if.dm_be); end
    checks++; if (sb_if.ld_stall !== 1'b0) begin failures++; $display("FAIL reset_ld_stall actual=%b required=0", sb_if.ld_stall); end
    checks++; if (sb_if.fwd_valid !== 1'b0) begin failures++; $display("FAIL reset_fwd_valid actual=%b required=0", sb_if.fwd_valid); end
    checks++; if (sb_if.fwd_data !== 32'h0) begin failures++; $display("FAIL reset_fwd_data actual=%h required=0", sb_if.fwd_data); end
  endtask

  task automatic test_single;
    do_reset();
    sb_if.dm_ready = 1'b1;
    put_store(32'h10, 32'h11223344, 4'hF, 32'h400);
    #1;
    checks++; if (sb_if.dm_we !== 1'b0) begin failures++; $display("FAIL single_same_cycle_we actual=%b required=0", sb_if.dm_we); end
    tick();
    sb_if.st_valid = 1'b0;
    #1;
    checks++; if (sb_if.dm_we !== 1'b1) begin failures++; $display("FAIL single_we actual=%b required=1", sb_if.dm_we); end
    checks++; if (sb_if.dm_addr !== 32'h10) begin failures++; $display("FAIL single_addr actual=%h required=00000010", sb_if.dm_addr); end
    checks++; if (sb_if.dm_wdata !== 32'h11223344) begin failures++; $display("FAIL single_wdata actual=%h required=11223344", sb_if.dm_wdata); end
    checks++; if (sb_if.dm_be !== 4'hF) begin failures++; $display("FAIL single_be actual=%h required=f", sb_if.dm_be); end
    checks++; if (sb_if.dm_pc !== 32'h400) begin failures++; $display("FAIL single_pc actual=%h required=00000400", sb_if.dm_pc); end
    tick();
    #1;
    checks++; if (sb_if.dm_we !== 1'b0) begin failures++; $display("FAIL single_empty_we actual=%b required=0", sb_if.dm_we); end
    checks++; if (sb_if.dm_addr !== 32'h0) begin failures++; $display("FAIL single_empty_addr actual=%h required=0", sb_if.dm_addr); end
  endtask

  task automatic test_fill_drain;
    logic exp_rdy;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      put_store(32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i), 4'hF, 32'h1000 + 32'(4 * i));
      #1;
      exp_rdy = (i < 4);
      checks++; if (sb_if.st_ready !== exp_rdy) begin failures++; $display("FAIL fill_st_ready[%0d] actual=%b required=%b", i, sb_if.st_ready, exp_rdy); end
      tick();
    end
    sb_if.st_valid = 1'b0;
    #1;
    checks++; if (sb_if.st_ready !== 1'b0) begin failures++; $display("FAIL fill_full actual=%b required=0", sb_if.st_ready); end
    checks++; if (sb_if.dm_addr !== 32'h100) begin failures++; $display("FAIL fill_head actual=%h required=00000100", sb_if.dm_addr); end
    tick();
    #1;
    checks++; if (sb_if.dm_addr !== 32'h100) begin failures++; $display("FAIL fill_head_held actual=%h required=00000100", sb_if.dm_addr); end
    sb_if.dm_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (sb_if.dm_we !== 1'b1) begin failures++; $display("FAIL drain_we[%0d] actual=%b required=1", i, sb_if.dm_we); end
      checks++; if (sb_if.dm_addr !== 32'h100 + 32'(4 * i)) begin failures++; $display("FAIL drain_addr[%0d] actual=%h required=%h", i, sb_if.dm_addr, 32'h100 + 32'(4 * i)); end
      checks++; if (sb_if.dm_wdata !== 32'hA000_0000 + 32'(i)) begin failures++; $display("FAIL drain_wdata[%0d] actual=%h required=%h", i, sb_if.dm_wdata, 32'hA000_0000 + 32'(i)); end
      tick();
    end
    #1;
    checks++; if (sb_if.dm_we !== 1'b0) begin failures++; $display("FAIL drain_empty actual=%b required=0", sb_if.dm_we); end
    checks++; if (sb_if.st_ready !== 1'b1) begin failures++; $display("FAIL drain_ready actual=%b required=1", sb_if.st_ready); end
  endtask

  task automatic test_full_simul;
    logic [31:0] exp_a [4];
    logic [31:0] exp_d [4];
    do_reset();
    for (int i = 0; i < 4; i++) begin
      put_store(32'h200 + 32'(4 * i), 32'hB000_0000 + 32'(i), 4'hF, 32'h0);
      tick();
    end
    // Full: dm_ready and st_valid together must not enqueue.
    put_store(32'h300, 32'hC000_0000, 4'hF, 32'h0);
    sb_if.dm_ready = 1'b1;
    #1;
    checks++; if (sb_if.st_ready !== 1'b0) begin failures++; $display("FAIL full_simul_ready actual=%b required=0", sb_if.st_ready); end
    tick();
    #1;
    checks++; if (sb_if.st_ready !== 1'b1) begin failures++; $display("FAIL full_after_deq_ready actual=%b required=1", sb_if.st_ready); end
    checks++; if (sb_if.dm_addr !== 32'h204) begin failures++; $display("FAIL full_after_deq_head actual=%h required=00000204", sb_if.dm_addr); end
    tick();  // enqueue 0x300 with dequeue of 0x204: count stays 3
    put_store(32'h304, 32'hC000_0001, 4'hF, 32'h0);
    sb_if.dm_ready = 1'b0;
    #1;
    checks++; if (sb_if.st_ready !== 1'b1) begin failures++; $display("FAIL simul_count3_ready actual=%b required=1", sb_if.st_ready); end
    checks++; if (sb_if.dm_addr !== 32'h208) begin failures++; $display("FAIL simul_head actual=%h required=00000208", sb_if.dm_addr); end
    tick();
    sb_if.st_valid = 1'b0;
    #1;
    checks++; if (sb_if.st_ready !== 1'b0) begin failures++; $display("FAIL simul_refull actual=%b required=0", sb_if.st_ready); end
    exp_a[0] = 32'h208; exp_d[0] = 32'hB000_0002;
    exp_a[1] = 32'h20C; exp_d[1] = 32'hB000_0003;
    exp_a[2] = 32'h300; exp_d[2] = 32'hC000_0000;
    exp_a[3] = 32'h304; exp_d[3] = 32'hC000_0001;
    sb_if.dm_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (sb_if.dm_addr !== exp_a[i] || sb_if.dm_wdata !== exp_d[i]) begin failures++; $display("FAIL simul_drain[%0d] actual=%h/%h required=%h/%h", i, sb_if.dm_addr, sb_if.dm_wdata, exp_a[i], exp_d[i]); end
      tick();
    end
    #1;
    checks++; if (sb_if.dm_we !== 1'b0) begin failures++; $display("FAIL simul_empty actual=%b required=0", sb_if.dm_we); end
  endtask

  task automatic test_fwd;
    do_reset();
    put_store(32'h20, 32'h0000BEEF, 4'h3, 32'h0);
    tick();
    sb_if.st_valid = 1'b0;
    sb_if.ld_valid = 1'b1;
    sb_if.ld_addr  = 32'h20;
    sb_if.ld_be    = 4'h1;
    #1;
`ifdef STORE_BUFFER_FWD_EN
    checks++; if (sb_if.fwd_valid !== 1'b1) begin failures++; $display("FAIL fwd_valid actual=%b required=1", sb_if.fwd_valid); end
    checks++; if (sb_if.fwd_data !== 32'h0000BEEF) begin failures++; $display("FAIL fwd_data actual=%h required=0000beef", sb_if.fwd_data); end
    checks++; if (sb_if.ld_stall !== 1'b0) begin failures++; $display("FAIL fwd_stall actual=%b required=0", sb_if.ld_stall); end
`else
    checks++; if (sb_if.ld_stall !== 1'b1) begin failures++; $display("FAIL match_stall actual=%b required=1", sb_if.ld_stall); end
    checks++; if (sb_if.fwd_valid !== 1'b0 || sb_if.fwd_data !== 32'h0) begin failures++; $display("FAIL match_nofwd actual=%b/%h required=0/0", sb_if.fwd_valid, sb_if.fwd_data); end
    tick();
    #1;
    checks++; if (sb_if.ld_stall !== 1'b1) begin failures++; $display("FAIL match_stall_held actual=%b required=1", sb_if.ld_stall); end
`endif
    sb_if.ld_valid = 1'b0;
    #1;
    checks++; if (sb_if.ld_stall !== 1'b0 || sb_if.fwd_valid !== 1'b0) begin failures++; $display("FAIL ld_idle actual=%b/%b required=0/0", sb_if.ld_stall, sb_if.fwd_valid); end
    sb_if.ld_valid = 1'b1;
    sb_if.dm_ready = 1'b1;
    tick();
    sb_if.dm_ready = 1'b0;
    #1;
    checks++; if (sb_if.ld_stall !== 1'b0 || sb_if.fwd_valid !== 1'b0) begin failures++; $display("FAIL drained_load actual=%b/%b required=0/0", sb_if.ld_stall, sb_if.fwd_valid); end
    sb_if.ld_valid = 1'b0;
  endtask

  task automatic test_partial;
    do_reset();
    put_store(32'h20, 32'h000000AA, 4'h1, 32'h0);
    tick();
    sb_if.st_valid = 1'b0;
    sb_if.ld_valid = 1'b1;
    sb_if.ld_addr  = 32'h22;
    sb_if.ld_be    = 4'h4;
    #1;
    checks++; if (sb_if.ld_stall !== 1'b1) begin failures++; $display("FAIL partial_stall actual=%b required=1", sb_if.ld_stall); end
    checks++; if (sb_if.fwd_valid !== 1'b0) begin failures++; $display("FAIL partial_fwd actual=%b required=0", sb_if.fwd_valid); end
    sb_if.ld_addr = 32'h24;
    sb_if.ld_be   = 4'hF;
    #1;
    checks++; if (sb_if.ld_stall !== 1'b0) begin failures++; $display("FAIL nomatch_stall actual=%b required=0", sb_if.ld_stall); end
    checks++; if (sb_if.fwd_valid !== 1'b0 || sb_if.fwd_data !== 32'h0) begin failures++; $display("FAIL nomatch_fwd actual=%b/%h required=0/0", sb_if.fwd_valid, sb_if.fwd_data); end
    sb_if.ld_valid = 1'b0;
  endtask

  task automatic test_youngest;
    do_reset();
    // Incoming store in the same cycle as the load is not compared.
    put_store(32'h30, 32'h11111111, 4'hF, 32'h0);
    sb_if.ld_valid = 1'b1;
    sb_if.ld_addr  = 32'h30;
    sb_if.ld_be    = 4'hF;
    #1;
    checks++; if (sb_if.ld_stall !== 1'b0 || sb_if.fwd_valid !== 1'b0) begin failures++; $display("FAIL same_cycle_store actual=%b/%b required=0/0", sb_if.ld_stall, sb_if.fwd_valid); end
    tick();
    put_store(32'h30, 32'h22222222, 4'hF, 32'h0);
    tick();
    sb_if.st_valid = 1'b0;
    #1;
`ifdef STORE_BUFFER_FWD_EN
    checks++; if (sb_if.fwd_valid !== 1'b1 || sb_if.fwd_data !== 32'h22222222) begin failures++; $display("FAIL youngest_fwd actual=%b/%h required=1/22222222", sb_if.fwd_valid, sb_if.fwd_data); end
`else
    checks++; if (sb_if.ld_stall !== 1'b1) begin failures++; $display("FAIL youngest_stall actual=%b required=1", sb_if.ld_stall); end
`endif
    sb_if.ld_valid = 1'b0;
  endtask

  task automatic test_reset_mid;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      put_store(32'h500 + 32'(4 * i), 32'hD000_0000 + 32'(i), 4'hF, 32'h0);
      tick();
    end
    // Reset overrides a same-edge enqueue.
    put_store(32'h600, 32'hE000_0000, 4'hF, 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb_if.st_valid = 1'b0;
    #1;
    checks++; if (sb_if.dm_we !== 1'b0) begin failures++; $display("FAIL midrst_we actual=%b required=0", sb_if.dm_we); end
    checks++; if (sb_if.st_ready !== 1'b1) begin failures++; $display("FAIL midrst_ready actual=%b required=1", sb_if.st_ready); end
    sb_if.dm_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (sb_if.dm_we !== 1'b0) begin failures++; $display("FAIL midrst_no_write[%0d] actual=%b required=0", i, sb_if.dm_we); end
      tick();
    end
    sb_if.dm_ready = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    idle_inputs();
    test_reset();
    test_single();
    test_fill_drain();
    test_full_simul();
    test_fwd();
    test_partial();
    test_youngest();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
